// File: rtl/drive_pkg.sv
// Shared encodings for the two-motor drive controller: FSM state codes,
// tone-detect turn commands and the H-bridge direction pin patterns.
package drive_pkg;

    localparam logic [2:0] ST_FWD       = 3'd0;
    localparam logic [2:0] ST_COLLIDE   = 3'd1;
    localparam logic [2:0] ST_REVERSE   = 3'd2;
    localparam logic [2:0] ST_JUNC_WAIT = 3'd3;
    localparam logic [2:0] ST_TURN      = 3'd4;

    localparam logic [1:0] TD_STRAIGHT = 2'b00;
    localparam logic [1:0] TD_LEFT     = 2'b01;
    localparam logic [1:0] TD_RIGHT    = 2'b10;
    localparam logic [1:0] TD_BACK     = 2'b11;

    // {In1, In2, In3, In4}
    localparam logic [3:0] PAT_FWD  = 4'b0110;
    localparam logic [3:0] PAT_REV  = 4'b1001;
    localparam logic [3:0] PAT_PIVL = 4'b1010;
    localparam logic [3:0] PAT_PIVR = 4'b0101;
    localparam logic [3:0] PAT_OFF  = 4'b0000;

    // Above this duty the bridge stalls the motors.
    localparam int FULL_PCT_MAX = 80;

    typedef struct packed {
        logic       enA;
        logic       enB;
        logic [3:0] pins;
    } bridgeCmd_t;

    function automatic int clampPct(input int pct, input int limit);
        return (pct > limit) ? limit : pct;
    endfunction

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bridgeCmd_t bridgeCmd(input logic enA, input logic enB,
                                             input logic [3:0] pins);
        bridgeCmd_t cmd;
        cmd.enA  = enA;
        cmd.enB  = enB;
        cmd.pins = pins;
        return cmd;
    endfunction

endpackage

// File: rtl/drive_controller_pwm_gen.sv
// Duty comparator against a shared PWM period counter; ON is the duty in percent.
module pwm_gen #(
    parameter int P  = 100,
    parameter int ON = 80,
    parameter int CW = 7
) (
    input  logic [CW-1:0] cnt,
    output logic          on
);
    localparam int THRESH = P * ON / 100;

    // Duty 0 gives a threshold of 0, so the output never asserts.
    assign on = (cnt < CW'(THRESH));

endmodule

// File: rtl/drive_controller.sv
// Two-motor H-bridge drive controller: line following, collision halt/back-off,
// junction turns measured in left-shaft encoder pulses.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  FWD        | follow the line from dir_ctrl; 1111 means junction
//  COLLIDE    | bridge off while col_n is low; long blockage -> REVERSE
//  REVERSE    | back off for BACKUP_PULSES shaft edges (or until stalled)
//  JUNC_WAIT  | bridge off until tone detection supplies a turn command
//  TURN       | execute the latched turn for its pulse target
module drive_controller
    import drive_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int PWM_HZ        = 80,
    parameter int FULL_PCT      = 80,
    parameter int VEER_PCT      = 20,
    parameter int TURN_PULSES   = 40,
    parameter int CLEAR_PULSES  = 10,
    parameter int BACKUP_PULSES = 20,
    parameter int COL_HOLD_CYC  = 25_000_000,
    parameter int STALL_CYC     = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dir_ctrl,
    input  logic       col_n,
    input  logic       td_en,
    input  logic [1:0] td_dir,
    input  logic       shaft_l,
    output logic       hb_en_a,
    output logic       hb_en_b,
    output logic [3:0] hb_in,
    output logic [2:0] state,
    output logic       busy
);
    localparam int P        = CLK_HZ / PWM_HZ;
    localparam int CNT_W    = $clog2(P + 1);
    localparam int FULL_EFF = clampPct(FULL_PCT, FULL_PCT_MAX);
    localparam int VEER_EFF = clampPct(VEER_PCT, FULL_EFF);
    localparam int MAX_TGT  = maxOf3(2 * TURN_PULSES, CLEAR_PULSES, BACKUP_PULSES);
    localparam int PULSE_W  = $clog2(MAX_TGT + 1);
    localparam int HOLD_W   = $clog2(COL_HOLD_CYC + 1);
    localparam int STALL_W  = $clog2(STALL_CYC + 1);

    logic [CNT_W-1:0]   pwmCnt;
    logic               fullOn;
    logic               veerOn;
    logic [2:0]         shaftSync;
    logic               shaftRise;
    logic [2:0]         stateNext;
    logic [HOLD_W-1:0]  holdCnt;
    logic [PULSE_W-1:0] pulseCnt;
    logic [PULSE_W-1:0] pulseInc;
    logic [PULSE_W-1:0] pulseTarget;
    logic [STALL_W-1:0] stallCnt;
    logic [1:0]         turnDir;
    logic               targetHit;
    logic               stallHit;
    logic               holdDone;
    bridgeCmd_t         driveNext;

    // Free-running PWM time base shared by both duty comparators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwmCnt <= '0;
        else if (pwmCnt == CNT_W'(P - 1))
            pwmCnt <= '0;
        else
            pwmCnt <= pwmCnt + CNT_W'(1);
    end

    pwm_gen #(.P(P), .ON(FULL_EFF), .CW(CNT_W)) uPwmFull (.cnt(pwmCnt), .on(fullOn));
    pwm_gen #(.P(P), .ON(VEER_EFF), .CW(CNT_W)) uPwmVeer (.cnt(pwmCnt), .on(veerOn));

    // Bring the asynchronous encoder pulse into clk and keep one extra stage for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shaftSync <= '0;
        else
            shaftSync <= {shaftSync[1:0], shaft_l};
    end

    assign shaftRise = shaftSync[1] & ~shaftSync[2];
    assign pulseInc  = (shaftRise && (pulseCnt != '1)) ? pulseCnt + PULSE_W'(1) : pulseCnt;
    assign holdDone  = (holdCnt == HOLD_W'(COL_HOLD_CYC - 1));
    assign stallHit  = !shaftRise && (stallCnt == STALL_W'(STALL_CYC - 1));
    assign targetHit = (pulseInc >= pulseTarget);

    // Pulse goal for the motion currently in progress
    always_comb begin
        pulseTarget = PULSE_W'(BACKUP_PULSES);
        if (state == ST_TURN) begin
            case (turnDir)
                TD_STRAIGHT: pulseTarget = PULSE_W'(CLEAR_PULSES);
                TD_BACK:     pulseTarget = PULSE_W'(2 * TURN_PULSES);
                default:     pulseTarget = PULSE_W'(TURN_PULSES);
            endcase
        end
    end

    // Next-state decision; collision outranks everything except an active back-off
    always_comb begin
        stateNext = state;
        case (state)
            ST_FWD: begin
                if (!col_n)
                    stateNext = ST_COLLIDE;
                else if (dir_ctrl == 4'b1111)
                    stateNext = ST_JUNC_WAIT;
            end
            ST_COLLIDE: begin
                if (col_n)
                    stateNext = ST_FWD;
                else if (holdDone)
                    stateNext = ST_REVERSE;
            end
            ST_REVERSE: begin
                if (targetHit || stallHit)
                    stateNext = ST_FWD;
            end
            ST_JUNC_WAIT: begin
                if (!col_n)
                    stateNext = ST_COLLIDE;
                else if (td_en)
                    stateNext = ST_TURN;
            end
            ST_TURN: begin
                if (!col_n)
                    stateNext = ST_COLLIDE;
                else if (targetHit || stallHit)
                    stateNext = ST_FWD;
            end
            default: stateNext = ST_FWD;
        endcase
    end

    // State, timers and turn latch; every state change starts the counters from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FWD;
            holdCnt  <= '0;
            pulseCnt <= '0;
            stallCnt <= '0;
            turnDir  <= TD_STRAIGHT;
        end else begin
            state <= stateNext;
            if (stateNext != state) begin
                holdCnt  <= '0;
                pulseCnt <= '0;
                stallCnt <= '0;
            end else begin
                if (state == ST_COLLIDE && !col_n)
                    holdCnt <= holdCnt + HOLD_W'(1);
                if (state == ST_TURN || state == ST_REVERSE) begin
                    pulseCnt <= pulseInc;
                    stallCnt <= shaftRise ? '0 : stallCnt + STALL_W'(1);
                end
            end
            if (state == ST_JUNC_WAIT && col_n && td_en)
                turnDir <= td_dir;
        end
    end

    // Bridge command for the current state and PWM phase
    always_comb begin
        driveNext = bridgeCmd(1'b0, 1'b0, PAT_OFF);
        case (state)
            ST_FWD: begin
                case (dir_ctrl)
                    4'b0000: driveNext = bridgeCmd(fullOn, fullOn, PAT_FWD);
                    4'b0101: driveNext = bridgeCmd(veerOn, fullOn, PAT_FWD);
                    4'b0111: driveNext = bridgeCmd(fullOn, fullOn, PAT_PIVL);
                    4'b1001: driveNext = bridgeCmd(fullOn, veerOn, PAT_FWD);
                    4'b1011: driveNext = bridgeCmd(fullOn, fullOn, PAT_PIVR);
                    default: driveNext = bridgeCmd(1'b0, 1'b0, PAT_OFF);
                endcase
            end
            ST_REVERSE: driveNext = bridgeCmd(fullOn, fullOn, PAT_REV);
            ST_TURN: begin
                case (turnDir)
                    TD_STRAIGHT: driveNext = bridgeCmd(fullOn, fullOn, PAT_FWD);
                    TD_LEFT:     driveNext = bridgeCmd(fullOn, fullOn, PAT_PIVL);
                    default:     driveNext = bridgeCmd(fullOn, fullOn, PAT_PIVR);
                endcase
            end
            default: driveNext = bridgeCmd(1'b0, 1'b0, PAT_OFF);
        endcase
    end

    // Registered bridge pins; reset forces the bridge off immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_en_a <= 1'b0;
            hb_en_b <= 1'b0;
            hb_in   <= PAT_OFF;
        end else begin
            hb_en_a <= driveNext.enA;
            hb_en_b <= driveNext.enB;
            hb_in   <= driveNext.pins;
        end
    end

    assign busy = (state == ST_JUNC_WAIT) || (state == ST_TURN) || (state == ST_REVERSE);

endmodule

// File: tb/tb_drive_controller.sv
// Bench for drive_controller with a small clock (P = 100) and short timers.
module tb_drive_controller;

    localparam int PER       = 100;
    localparam int FULL_ON   = 80;
    localparam int VEER_ON   = 20;
    localparam int HOLD      = 10;
    localparam int STALL     = 50;
    localparam int BACKUP    = 20;
    localparam int TURN_P    = 40;
    localparam int CLEAR_P   = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dir_ctrl = 4'b0000;
    logic       col_n = 1'b1;
    logic       td_en = 1'b0;
    logic [1:0] td_dir = 2'b00;
    logic       shaft_l = 1'b0;
    logic       hb_en_a;
    logic       hb_en_b;
    logic [3:0] hb_in;
    logic [2:0] state;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int busyLowCnt = 0;

    // reference model
    string      mode;
    int         mHold, mPulses, mQuiet, mCyc;
    logic [1:0] mDir;
    bit         sh1, sh2, sh3;
    logic       expEnA, expEnB, expBusy;
    logic [3:0] expPins;

    typedef struct {
        logic [3:0] code;
        int         highA;
        int         highB;
        logic [3:0] pins;
    } fwdVec_t;

    fwdVec_t vecs[8];

    drive_controller #(
        .CLK_HZ(1000), .PWM_HZ(10), .FULL_PCT(80), .VEER_PCT(20),
        .TURN_PULSES(TURN_P), .CLEAR_PULSES(CLEAR_P), .BACKUP_PULSES(BACKUP),
        .COL_HOLD_CYC(HOLD), .STALL_CYC(STALL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dir_ctrl(dir_ctrl), .col_n(col_n),
        .td_en(td_en), .td_dir(td_dir), .shaft_l(shaft_l),
        .hb_en_a(hb_en_a), .hb_en_b(hb_en_b), .hb_in(hb_in),
        .state(state), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic enter(input string m);
        mode    = m;
        mHold   = 0;
        mPulses = 0;
        mQuiet  = 0;
    endtask

    task automatic modelReset();
        enter("FWD");
        mDir = 2'b00;
        sh1 = 0; sh2 = 0; sh3 = 0;
        mCyc = 0;
    endtask

    function automatic int turnGoal(input logic [1:0] d);
        case (d)
            2'b00:   return CLEAR_P;
            2'b11:   return 2 * TURN_P;
            default: return TURN_P;
        endcase
    endfunction

    // One clock of the behavioural model: pins follow the mode held during the
    // cycle, then the mode advances on the sampled inputs.
    task automatic modelStep();
        bit rise;
        bit fullOn, veerOn;
        int phase, goal;
        rise   = sh2 && !sh3;
        phase  = mCyc % PER;
        fullOn = phase < FULL_ON;
        veerOn = phase < VEER_ON;
        expEnA = 0; expEnB = 0; expPins = 4'b0000;
        if (mode == "FWD") begin
            if (dir_ctrl == 4'b0000) begin expEnA = fullOn; expEnB = fullOn; expPins = 4'b0110; end
            if (dir_ctrl == 4'b0101) begin expEnA = veerOn; expEnB = fullOn; expPins = 4'b0110; end
            if (dir_ctrl == 4'b0111) begin expEnA = fullOn; expEnB = fullOn; expPins = 4'b1010; end
            if (dir_ctrl == 4'b1001) begin expEnA = fullOn; expEnB = veerOn; expPins = 4'b0110; end
            if (dir_ctrl == 4'b1011) begin expEnA = fullOn; expEnB = fullOn; expPins = 4'b0101; end
        end else if (mode == "REVERSE") begin
            expEnA = fullOn; expEnB = fullOn; expPins = 4'b1001;
        end else if (mode == "TURN") begin
            expEnA = fullOn; expEnB = fullOn;
            expPins = (mDir == 2'b00) ? 4'b0110 : (mDir == 2'b01) ? 4'b1010 : 4'b0101;
        end

        if (mode == "FWD") begin
            if (!col_n) enter("COLLIDE");
            else if (dir_ctrl == 4'b1111) enter("JUNC");
        end else if (mode == "COLLIDE") begin
            if (col_n) enter("FWD");
            else begin
                mHold++;
                if (mHold >= HOLD) enter("REVERSE");
            end
        end else if (mode == "JUNC") begin
            if (!col_n) enter("COLLIDE");
            else if (td_en) begin
                mDir = td_dir;
                enter("TURN");
            end
        end else if (mode == "TURN" && !col_n) begin
            enter("COLLIDE");
        end else begin
            goal = (mode == "REVERSE") ? BACKUP : turnGoal(mDir);
            mPulses += int'(rise);
            if (mPulses >= goal) enter("FWD");
            else begin
                mQuiet = rise ? 0 : mQuiet + 1;
                if (mQuiet >= STALL) enter("FWD");
            end
        end

        expBusy = (mode == "JUNC") || (mode == "TURN") || (mode == "REVERSE");
        sh3 = sh2; sh2 = sh1; sh1 = shaft_l;
        mCyc++;
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        if (!busy) busyLowCnt++;
        check("model", {8'h00, hb_en_a, hb_en_b, hb_in, busy, state == 3'd0},
              {8'h00, expEnA, expEnB, expPins, expBusy, mode == "FWD"});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse();
        shaft_l = 1'b1; step(); step();
        shaft_l = 1'b0; step(); step();
    endtask

    task automatic startTurn(input logic [1:0] d);
        dir_ctrl = 4'b1111; step(); step();
        dir_ctrl = 4'b0000; td_en = 1'b1; td_dir = d; step();
        td_en = 1'b0;
    endtask

    initial begin
        int cntA, cntB, n, burst;
        vecs[0] = '{4'b0000, 80, 80, 4'b0110};
        vecs[1] = '{4'b0101, 20, 80, 4'b0110};
        vecs[2] = '{4'b0111, 80, 80, 4'b1010};
        vecs[3] = '{4'b1001, 80, 20, 4'b0110};
        vecs[4] = '{4'b1011, 80, 80, 4'b0101};
        vecs[5] = '{4'b0011, 0, 0, 4'b0000};
        vecs[6] = '{4'b1100, 0, 0, 4'b0000};
        vecs[7] = '{4'b0110, 0, 0, 4'b0000};

        @(negedge clk); @(negedge clk);
        check("reset_outputs", {7'd0, hb_en_a, hb_en_b, hb_in, state, busy}, 16'h0000);
        modelReset();
        rst_n = 1'b1;

        // line-following duty and pattern table
        for (int v = 0; v < 8; v++) begin
            dir_ctrl = vecs[v].code;
            step();
            cntA = 0; cntB = 0;
            for (int i = 0; i < PER; i++) begin
                step();
                cntA += int'(hb_en_a);
                cntB += int'(hb_en_b);
            end
            check($sformatf("duty_a_%b", vecs[v].code), 16'(cntA), 16'(vecs[v].highA));
            check($sformatf("duty_b_%b", vecs[v].code), 16'(cntB), 16'(vecs[v].highB));
            check($sformatf("pins_%b", vecs[v].code), {12'd0, hb_in}, {12'd0, vecs[v].pins});
        end

        // short collision: halt, no back-off
        dir_ctrl = 4'b0000; step();
        busyLowCnt = 0;
        col_n = 1'b0; steps(3);
        check("collide_off", {10'd0, hb_en_a, hb_en_b, hb_in}, 16'h0000);
        steps(2);
        col_n = 1'b1; steps(3);
        check("short_col_no_rev", 16'(busyLowCnt), 16'd8);
        check("short_col_fwd", {13'd0, state}, 16'd0);

        // persistent collision: reverse for BACKUP pulses
        col_n = 1'b0; steps(12);
        check("rev_entered", {11'd0, busy, hb_in}, {11'd0, 1'b1, 4'b1001});
        col_n = 1'b1;
        for (int i = 0; i < BACKUP - 1; i++) pulse();
        check("rev_before_target", {15'd0, busy}, 16'd1);
        pulse();
        check("rev_done", {12'd0, busy, state}, 16'd0);

        // BACK turn needs exactly 2*TURN_PULSES edges
        steps(4);
        startTurn(2'b11);
        busyLowCnt = 0;
        step();
        check("back_pattern", {12'd0, hb_in}, {12'd0, 4'b0101});
        for (int i = 0; i < 2 * TURN_P - 1; i++) pulse();
        check("back_busy_all", 16'(busyLowCnt), 16'd0);
        pulse();
        check("back_done", {12'd0, busy, state}, 16'd0);

        // LEFT turn with no encoder edges ends on the stall timeout
        steps(4);
        startTurn(2'b01);
        n = 0;
        while (state != 3'd0 && n < 200) begin step(); n++; end
        check("stall_exit_clks", 16'(n), 16'(STALL));

        // collision mid-turn aborts to COLLIDE, then resumes in FWD
        steps(2);
        startTurn(2'b01);
        steps(20);
        col_n = 1'b0; steps(2);
        check("turn_abort_collide", {12'd0, busy, state == 3'd0, 2'b00}, 16'd0);
        col_n = 1'b1; steps(2);
        check("turn_abort_fwd", {13'd0, state}, 16'd0);

        // asynchronous reset in the middle of a turn
        startTurn(2'b10);
        steps(5);
        rst_n = 1'b0;
        #1;
        check("async_rst", {7'd0, hb_en_a, hb_en_b, hb_in, state, busy}, 16'h0000);
        @(negedge clk); @(negedge clk);
        modelReset();
        rst_n = 1'b1;

        // randomized traffic against the model
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    dir_ctrl = 4'b0000;
                    2:       dir_ctrl = 4'b0101;
                    3:       dir_ctrl = 4'b0111;
                    4:       dir_ctrl = 4'b1001;
                    5:       dir_ctrl = 4'b1011;
                    6:       dir_ctrl = 4'b1111;
                    7:       dir_ctrl = 4'b0010;
                    default: dir_ctrl = 4'($urandom_range(0, 15));
                endcase
            end
            if (burst > 0) begin
                col_n = 1'b0;
                burst--;
            end else begin
                col_n = 1'b1;
                if ($urandom_range(0, 59) == 0) burst = $urandom_range(1, 14);
            end
            td_en  = ($urandom_range(0, 7) == 0);
            td_dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) shaft_l = ~shaft_l;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
